// File: rtl/mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : mem_responder
// Description : Single-port 32-bit word memory behind a fixed-latency
//               IDLE/WAIT/DONE request handshake with sticky request-error flag.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_responder #(
    parameter int LATENCY = 2,
    parameter int DEPTH   = 512
) (
    input  logic        clk,
    input  logic        Clear,
    input  logic [8:0]  Address,
    input  logic [31:0] DataIn,
    input  logic        Read,
    input  logic        Write,
    output logic [31:0] DataOut,
    output logic        Done,
    output logic        Busy,
    output logic        ReqErr
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [3:0] c_CNT_LOAD = 4'(LATENCY - 1);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [3:0]  r_cnt;
    logic [3:0]  w_cnt_nxt;
    logic [8:0]  r_addr;
    logic [31:0] r_wdata;
    logic        r_is_wr;
    logic        w_capture;
    logic        w_commit;
    logic        w_busy_nxt;
    logic        w_done_nxt;
    logic        w_err_nxt;

    logic [31:0] r_mem [DEPTH];

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_capture   = 1'b0;
        w_commit    = 1'b0;
        w_busy_nxt  = Busy;
        w_done_nxt  = 1'b0;
        w_err_nxt   = ReqErr;
        case (r_state)
            S_IDLE: begin
                w_busy_nxt = 1'b0;
                if (Read && Write) begin
                    w_err_nxt = 1'b1;
                end else if (Read || Write) begin
                    w_capture   = 1'b1;
                    w_state_nxt = S_WAIT;
                    w_cnt_nxt   = c_CNT_LOAD;
                    w_busy_nxt  = 1'b1;
                end
            end
            S_WAIT: begin
                // The access itself happens on the edge that completes the wait.
                if (r_cnt == 4'd0) begin
                    w_state_nxt = S_DONE;
                    w_done_nxt  = 1'b1;
                    w_commit    = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
                w_busy_nxt  = 1'b0;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (Clear) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_addr  <= 9'd0;
            r_wdata <= 32'd0;
            r_is_wr <= 1'b0;
            DataOut <= 32'd0;
            Done    <= 1'b0;
            Busy    <= 1'b0;
            ReqErr  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            Done    <= w_done_nxt;
            Busy    <= w_busy_nxt;
            ReqErr  <= w_err_nxt;
            if (w_capture) begin
                r_addr  <= Address;
                r_wdata <= DataIn;
                r_is_wr <= Write;
            end
            if (w_commit && !r_is_wr) begin
                DataOut <= r_mem[r_addr];
            end
        end
    end

    // Memory is never reset; Clear only blocks a pending commit.
    always_ff @(posedge clk) begin
        if (!Clear && w_commit && r_is_wr) begin
            r_mem[r_addr] <= r_wdata;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_responder
// Description : Directed + randomized self-checking bench for mem_responder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_responder;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        Clear;
    logic        Read;
    logic        Write;
    logic [8:0]  Address;
    logic [31:0] DataIn;
    logic [31:0] DataOut, dout1, dout15;
    logic        Done, done1, done15;
    logic        Busy, busy1, busy15;
    logic        ReqErr, err1, err15;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [31:0] ref_mem [512];
    logic [31:0] ref_dout;
    logic        ref_err;

    always #5 clk = ~clk;

    mem_responder #(.LATENCY(LAT), .DEPTH(512)) u_dut (
        .clk(clk), .Clear(Clear), .Address(Address), .DataIn(DataIn),
        .Read(Read), .Write(Write), .DataOut(DataOut), .Done(Done),
        .Busy(Busy), .ReqErr(ReqErr));

    mem_responder #(.LATENCY(1), .DEPTH(512)) u_dut1 (
        .clk(clk), .Clear(Clear), .Address(Address), .DataIn(DataIn),
        .Read(Read), .Write(Write), .DataOut(dout1), .Done(done1),
        .Busy(busy1), .ReqErr(err1));

    mem_responder #(.LATENCY(15), .DEPTH(512)) u_dut15 (
        .clk(clk), .Clear(Clear), .Address(Address), .DataIn(DataIn),
        .Read(Read), .Write(Write), .DataOut(dout15), .Done(done15),
        .Busy(busy15), .ReqErr(err15));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_clear();
        Clear = 1'b1;
        Read  = 1'b0;
        Write = 1'b0;
        tick();
        Clear    = 1'b0;
        ref_dout = 32'd0;
        ref_err  = 1'b0;
    endtask

    // One complete transaction; optional jitter scrambles every input while waiting.
    task automatic txn(input bit is_wr, input logic [8:0] a, input logic [31:0] d,
                       input bit jitter);
        int n;
        int bcnt;
        Read    = !is_wr;
        Write   = is_wr;
        Address = a;
        DataIn  = d;
        tick();
        chk("cap_busy", {31'd0, Busy}, 32'd1);
        chk("cap_done", {31'd0, Done}, 32'd0);
        Read  = 1'b0;
        Write = 1'b0;
        bcnt  = 1;
        n     = 0;
        while (Done !== 1'b1 && n < 40) begin
            if (jitter) begin
                Address = 9'($urandom);
                DataIn  = $urandom;
                Read    = 1'($urandom);
                Write   = 1'($urandom);
            end
            tick();
            n++;
            if (Busy === 1'b1) bcnt++;
        end
        Read  = 1'b0;
        Write = 1'b0;
        chk("done_latency", n, LAT);
        if (is_wr) ref_mem[a] = d;
        else       ref_dout   = ref_mem[a];
        chk("dataout", DataOut, ref_dout);
        chk("reqerr", {31'd0, ReqErr}, {31'd0, ref_err});
        tick();
        chk("done_one_cycle", {31'd0, Done}, 32'd0);
        chk("busy_after_done", {31'd0, Busy}, 32'd0);
        chk("busy_cycles", bcnt, LAT + 1);
    endtask

    initial begin
        int lat [3];
        int first [3];
        int prev [3];
        int nrise [3];
        int perr [3];
        logic last [3];
        logic dv;
        int c0;
        bit saw_done;
        logic [8:0] a;

        foreach (ref_mem[i]) ref_mem[i] = 32'd0;
        Clear = 1'b0; Read = 1'b0; Write = 1'b0; Address = 9'd0; DataIn = 32'd0;
        tick();
        do_clear();
        chk("rst_dataout", DataOut, 32'd0);
        chk("rst_done", {31'd0, Done}, 32'd0);
        chk("rst_busy", {31'd0, Busy}, 32'd0);
        chk("rst_reqerr", {31'd0, ReqErr}, 32'd0);

        // Unwritten location reads as zero
        txn(1'b0, 9'h000, 32'd0, 1'b0);
        // Write then read back
        txn(1'b1, 9'h1A3, 32'hDEADBEEF, 1'b0);
        txn(1'b0, 9'h1A3, 32'd0, 1'b0);

        // Simultaneous Read and Write
        Read = 1'b1; Write = 1'b1; Address = 9'h1A3;
        tick();
        ref_err = 1'b1;
        chk("both_err", {31'd0, ReqErr}, 32'd1);
        chk("both_busy", {31'd0, Busy}, 32'd0);
        chk("both_done", {31'd0, Done}, 32'd0);
        Read = 1'b0; Write = 1'b0;
        tick();
        chk("both_done2", {31'd0, Done}, 32'd0);
        txn(1'b0, 9'h1A3, 32'd0, 1'b0);

        // Clear aborts a write before its commit edge
        txn(1'b1, 9'h0FF, 32'hA5A5A5A5, 1'b0);
        Write = 1'b1; Address = 9'h0FF; DataIn = 32'h12345678;
        tick();
        Write = 1'b0;
        Clear = 1'b1;
        tick();
        Clear = 1'b0; ref_dout = 32'd0; ref_err = 1'b0;
        chk("abort_dataout", DataOut, 32'd0);
        chk("abort_busy", {31'd0, Busy}, 32'd0);
        chk("abort_reqerr", {31'd0, ReqErr}, 32'd0);
        saw_done = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (Done === 1'b1) saw_done = 1'b1;
            tick();
        end
        chk("abort_no_done", {31'd0, saw_done}, 32'd0);
        txn(1'b0, 9'h0FF, 32'd0, 1'b0);

        // Inputs scrambled during WAIT must not affect the captured request
        txn(1'b1, 9'h001, 32'hCAFEF00D, 1'b1);
        txn(1'b1, 9'h1FF, 32'h0BADC0DE, 1'b1);
        txn(1'b0, 9'h001, 32'd0, 1'b0);
        txn(1'b0, 9'h1FF, 32'd0, 1'b1);

        // Randomized traffic against the reference memory
        for (int k = 0; k < 24; k++) begin
            case ($urandom_range(0, 4))
                0:       a = 9'h1A3;
                1:       a = 9'h0FF;
                2:       a = 9'h001;
                3:       a = 9'h1FF;
                default: a = 9'($urandom);
            endcase
            txn(1'($urandom), a, $urandom, 1'($urandom));
            if ($urandom_range(0, 2) == 0) begin
                tick();
                chk("idle_busy", {31'd0, Busy}, 32'd0);
            end
        end

        // Continuous Read on three latency builds
        do_clear();
        chk("lat1_dout_rst", dout1, 32'd0);
        chk("lat15_dout_rst", dout15, 32'd0);
        lat[0] = LAT; lat[1] = 1; lat[2] = 15;
        for (int i = 0; i < 3; i++) begin
            first[i] = -1; prev[i] = 0; nrise[i] = 0; perr[i] = 0; last[i] = 1'b0;
        end
        Read = 1'b1; Address = 9'h1A3;
        c0 = cyc + 1;
        for (int t = 0; t < 60; t++) begin
            tick();
            for (int i = 0; i < 3; i++) begin
                dv = (i == 0) ? Done : ((i == 1) ? done1 : done15);
                if (dv === 1'b1 && last[i] !== 1'b1) begin
                    if (nrise[i] == 0) first[i] = cyc;
                    else if (cyc - prev[i] != lat[i] + 2) perr[i]++;
                    prev[i] = cyc;
                    nrise[i]++;
                end
                last[i] = dv;
            end
        end
        Read = 1'b0;
        ref_dout = ref_mem[9'h1A3];
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("first_done_lat%0d", lat[i]), first[i], c0 + lat[i]);
            chk($sformatf("period_lat%0d", lat[i]), perr[i], 0);
            chk($sformatf("repeats_lat%0d", lat[i]), {31'd0, nrise[i] >= 2}, 32'd1);
        end
        chk("held_read_data", DataOut, ref_dout);
        for (int t = 0; t < 20; t++) tick();
        chk("lat1_idle", {31'd0, busy1}, 32'd0);
        chk("lat15_idle", {31'd0, busy15}, 32'd0);
        chk("lat1_err", {31'd0, err1}, 32'd0);
        chk("lat15_err", {31'd0, err15}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter LATENCY, default 2: wait cycles between request capture and completion; legal range 1..15.
REQ-002 Parameter DEPTH, default 512: number of 32-bit words, matching the 9-bit address space.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Clear  input  1  synchronous active-high reset.
REQ-005 Address  input  9  word address driven by the memory address register.
REQ-006 DataIn  input  32  write data.
REQ-007 Read  input  1  read request, level-sampled in IDLE.
REQ-008 Write  input  1  write request, level-sampled in IDLE.
REQ-009 DataOut  output  32  read data, registered.
REQ-010 Done  output  1  one-cycle completion pulse, registered.
REQ-011 Busy  output  1  high while a request is in progress, registered.
REQ-012 ReqErr  output  1  sticky flag, set on an illegal request.

Function
REQ-013 Storage SHALL be DEPTH x 32-bit words; the full 9-bit Address indexes it, with no wrap or masking.
REQ-014 The FSM SHALL have three states: IDLE, WAIT and DONE.
REQ-015 IDLE, exactly one of Read/Write high at edge E0: capture Address, DataIn and the op; go to WAIT; load the counter with LATENCY-1; set Busy=1.
REQ-016 IDLE, Read and Write both high: no access; set ReqErr=1; stay in IDLE.
REQ-017 IDLE, neither Read nor Write high: hold; Busy=0.
REQ-018 WAIT: decrement the counter each edge.
REQ-019 WAIT, edge where the counter equals 0: go to DONE; Done=1.
REQ-020 WAIT, read op, same edge: DataOut <= mem[captured Address].
REQ-021 WAIT, write op, same edge: mem[captured Address] <= captured DataIn; DataOut unchanged.
REQ-022 Done SHALL first be high after edge E0+LATENCY and stay high for exactly one cycle.
REQ-023 DONE: next edge go to IDLE; Done=0; Busy=0.
REQ-024 Read/Write SHALL be ignored in WAIT and DONE; captured values SHALL be unaffected by input changes after E0.
REQ-025 A request held high into IDLE after DONE SHALL start a new transaction; the initiator must drop its request on seeing Done.
REQ-026 Back-to-back requests: minimum spacing LATENCY+2 edges between captures.
REQ-027 DataOut SHALL hold the last read value until the next read completes.
REQ-028 Read-after-write to the same address SHALL return the written data.
REQ-029 ReqErr SHALL remain set until Clear.

Reset
REQ-030 Clear high at an edge: state=IDLE; counter=0; DataOut=0; Done=0; Busy=0; ReqErr=0.
REQ-031 Clear SHALL take priority over all other inputs.
REQ-032 Clear mid-transaction (WAIT or DONE) SHALL abort it: no memory write is committed unless the commit edge precedes the Clear edge.
REQ-033 Clear SHALL NOT modify memory contents; simulation initial contents are all zero.

Verification
REQ-034 Write 0xDEADBEEF to 0x1A3, then read 0x1A3 -> Done after E0+2 each time; DataOut=0xDEADBEEF.
REQ-035 Read 0x000 after Clear, without prior write -> DataOut=0x00000000; Busy high for 3 cycles.
REQ-036 Read=Write=1 in IDLE -> ReqErr=1, Busy=0, no Done; later valid read completes normally, ReqErr still 1.
REQ-037 Write 0x12345678 to 0x0FF, Clear asserted in WAIT before the commit edge -> read 0x0FF returns the previous value; Done never pulses for the aborted op.
REQ-038 Address or DataIn changed in WAIT during a write to 0x001 -> only the originally captured address/data written; address 0x1FF also exercised.
REQ-039 LATENCY=1 and LATENCY=15 builds: Done rises exactly LATENCY edges after capture; Read held continuously -> transactions repeat every LATENCY+2 edges.
